quad_decoder_bcd: RTL and testbench

- Input-side counterpart to the display path: decodes a two-channel quadrature encoder (A/B) into signed steps.
- Accumulates the steps in a 4-digit packed-BCD up/down counter.
- o_bcd feeds the existing 4-digit 7-segment display path, replacing the free-running 1 Hz BCD source.
- Input sampling is paced by an external enable tick from the existing enable generator, so debounce time is set by that generator's divisor.

---
 rtl/quad_decoder_bcd_pkg.sv | 50 +++++
 rtl/quad_decoder_bcd_digit.sv | 36 +++
 rtl/quad_decoder_bcd.sv | 147 ++++++++++++++
 tb/tb_quad_decoder_bcd.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_bcd_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder / BCD counter.
package quad_pkg;

    // Encoder channel pair, packed as {A, B}
    typedef logic [1:0] quad_state_t;

    // One packed-BCD digit, always 0..9
    typedef logic [3:0] bcd_digit_t;

    // Result of comparing the previous and the new filtered pair
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_t;

    localparam quad_state_t QUAD_00 = 2'b00;
    localparam quad_state_t QUAD_01 = 2'b01;
    localparam quad_state_t QUAD_11 = 2'b11;
    localparam quad_state_t QUAD_10 = 2'b10;

    localparam bcd_digit_t BCD_MIN = 4'd0;
    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Next pair when turning up: 00 -> 01 -> 11 -> 10 -> 00
    function automatic quad_state_t gray_next_up(input quad_state_t s);
        quad_state_t n;
        case (s)
            QUAD_00: n = QUAD_01;
            QUAD_01: n = QUAD_11;
            QUAD_11: n = QUAD_10;
            default: n = QUAD_00;
        endcase
        return n;
    endfunction

    // Next pair when turning down: reverse of the up sequence
    function automatic quad_state_t gray_next_dn(input quad_state_t s);
        quad_state_t n;
        case (s)
            QUAD_00: n = QUAD_10;
            QUAD_10: n = QUAD_11;
            QUAD_11: n = QUAD_01;
            default: n = QUAD_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_decoder_bcd_digit.sv
// One registered BCD up/down digit with combinational carry/borrow out.
module bcd_updown_digit
    import quad_pkg::*;
#(
    parameter logic [3:0] INIT_DIGIT = 4'd0
) (
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_borrow
);

    bcd_digit_t digit;

    assign o_digit  = digit;
    assign o_carry  = i_inc && (digit == BCD_MAX);
    assign o_borrow = i_dec && (digit == BCD_MIN);

    // Digit register: clear loads the init value, otherwise wrap 9<->0
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= INIT_DIGIT;
        end else if (i_clear) begin
            digit <= INIT_DIGIT;
        end else if (i_inc) begin
            digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
        end else if (i_dec) begin
            digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/quad_decoder_bcd.sv
// Quadrature encoder decoder: synchronise, debounce on sample ticks,
// decode Gray transitions and accumulate into a 4-digit BCD counter.
module quad_decoder_bcd
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter bit          X4_MODE    = 1'b1,
    parameter logic [15:0] INIT_BCD   = 16'h0000
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic        i_quad_a,
    input  logic        i_quad_b,
    input  logic        i_sample_en,
    input  logic        i_clear,
    output logic [15:0] o_bcd,
    output logic        o_step,
    output logic        o_dir,
    output logic        o_err
);

    localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

    quad_state_t meta_ab;
    quad_state_t sync_ab;
    quad_state_t filt_ab;
    quad_state_t prev_ab;
    logic [3:0]  flt_cnt;
    step_t       step_c;
    step_t       step_q;
    logic        count_up;
    logic        count_dn;
    logic [4:0]  inc_chain;
    logic [4:0]  dec_chain;
    logic        wrap_unused;
    logic        step_r;
    logic        dir_r;
    logic        err_r;

    // Two-flop synchroniser on both encoder channels
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_ab <= '0;
            sync_ab <= '0;
        end else begin
            meta_ab <= {i_quad_a, i_quad_b};
            sync_ab <= meta_ab;
        end
    end

    // Debounce: a new pair must differ on FILTER_LEN consecutive ticks
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_ab <= '0;
            flt_cnt <= '0;
        end else if (i_sample_en) begin
            if (sync_ab == filt_ab) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                filt_ab <= sync_ab;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 4'd1;
            end
        end
    end

    // Classify the filtered transition; x1 mode counts only entry into 00
    always_comb begin
        step_c = STEP_NONE;
        if (filt_ab != prev_ab) begin
            if (filt_ab == gray_next_up(prev_ab)) begin
                if (X4_MODE || (filt_ab == QUAD_00)) step_c = STEP_UP;
            end else if (filt_ab == gray_next_dn(prev_ab)) begin
                if (X4_MODE || (filt_ab == QUAD_00)) step_c = STEP_DN;
            end else begin
                step_c = STEP_ERR;
            end
        end
    end

    // Decoder register: remember the last filtered pair and the step found
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab <= '0;
            step_q  <= STEP_NONE;
        end else begin
            prev_ab <= filt_ab;
            step_q  <= step_c;
        end
    end

    // Clear wins over a step arriving in the same cycle
    assign count_up = (step_q == STEP_UP) && !i_clear;
    assign count_dn = (step_q == STEP_DN) && !i_clear;

    assign inc_chain[0] = count_up;
    assign dec_chain[0] = count_dn;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_digit
            bcd_updown_digit #(
                .INIT_DIGIT (INIT_BCD[4*k +: 4])
            ) u_digit (
                .i_clk    (i_clk),
                .rst_n    (rst_n),
                .i_clear  (i_clear),
                .i_inc    (inc_chain[k]),
                .i_dec    (dec_chain[k]),
                .o_digit  (o_bcd[4*k +: 4]),
                .o_carry  (inc_chain[k+1]),
                .o_borrow (dec_chain[k+1])
            );
        end
    endgenerate

    // Carry/borrow out of the thousands digit is the 9999<->0000 wrap;
    // nothing downstream needs it.
    assign wrap_unused = inc_chain[4] | dec_chain[4];

    // Step pulse, direction and sticky error, aligned with the digit update
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r <= 1'b0;
            dir_r  <= 1'b1;
            err_r  <= 1'b0;
        end else begin
            step_r <= count_up | count_dn;
            if (count_up) begin
                dir_r <= 1'b1;
            end else if (count_dn) begin
                dir_r <= 1'b0;
            end
            if (i_clear) begin
                err_r <= 1'b0;
            end else if (step_q == STEP_ERR) begin
                err_r <= 1'b1;
            end
        end
    end

    assign o_step = step_r;
    assign o_dir  = dir_r;
    assign o_err  = err_r;

endmodule

// File: tb/tb_quad_decoder_bcd.sv
// Randomised bench for quad_decoder_bcd: an x4 instance and an x1 instance
// share the encoder inputs and are checked against a position-based model.
module tb_quad_decoder_bcd;

    localparam int unsigned FLT   = 4;
    localparam logic [15:0] INIT1 = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        qa = 1'b0;
    logic        qb = 1'b0;
    logic        sample_en = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] bcd [2];
    logic        step_o [2];
    logic        dir_o [2];
    logic        err_o [2];

    quad_decoder_bcd #(
        .FILTER_LEN (FLT),
        .X4_MODE    (1'b1),
        .INIT_BCD   (16'h0000)
    ) dut_x4 (
        .i_clk       (clk),
        .rst_n       (rst_n),
        .i_quad_a    (qa),
        .i_quad_b    (qb),
        .i_sample_en (sample_en),
        .i_clear     (clear),
        .o_bcd       (bcd[0]),
        .o_step      (step_o[0]),
        .o_dir       (dir_o[0]),
        .o_err       (err_o[0])
    );

    quad_decoder_bcd #(
        .FILTER_LEN (FLT),
        .X4_MODE    (1'b0),
        .INIT_BCD   (INIT1)
    ) dut_x1 (
        .i_clk       (clk),
        .rst_n       (rst_n),
        .i_quad_a    (qa),
        .i_quad_b    (qb),
        .i_sample_en (sample_en),
        .i_clear     (clear),
        .o_bcd       (bcd[1]),
        .o_step      (step_o[1]),
        .o_dir       (dir_o[1]),
        .o_err       (err_o[1])
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample tick: continuous, or one tick every third clock
    bit se_cont = 1'b1;
    int div = 0;
    always @(negedge clk) begin
        if (se_cont) begin
            sample_en = 1'b1;
        end else begin
            sample_en = (div == 2);
            div = (div == 2) ? 0 : div + 1;
        end
    end

    // Count observed step pulses
    int obs_steps [2] = '{0, 0};
    always @(negedge clk) begin
        if (step_o[0]) obs_steps[0]++;
        if (step_o[1]) obs_steps[1]++;
    end

    // Reference model: encoder position on the ring 00,01,11,10 and an integer count
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] m_prev = 2'b00;
    int  init_val [2] = '{0, 1234};
    int  m_val [2]   = '{0, 1234};
    bit  m_dir [2]   = '{1'b1, 1'b1};
    bit  m_err [2]   = '{1'b0, 1'b0};
    int  m_steps [2] = '{0, 0};

    function automatic int pos_of(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int settle();
        return se_cont ? 12 : 21;
    endfunction

    task automatic model_move(input logic [1:0] p, input bit drop);
        int d;
        d = (pos_of(p) - pos_of(m_prev) + 4) % 4;
        for (int i = 0; i < 2; i++) begin
            if (d == 2) begin
                m_err[i] = 1'b1;
            end else if (d != 0 && (i == 0 || p == 2'b00) && !drop) begin
                if (d == 1) begin
                    m_val[i] = (m_val[i] + 1) % 10000;
                    m_dir[i] = 1'b1;
                end else begin
                    m_val[i] = (m_val[i] + 9999) % 10000;
                    m_dir[i] = 1'b0;
                end
                m_steps[i]++;
            end
            if (drop) begin
                m_val[i] = init_val[i];
                m_err[i] = 1'b0;
            end
        end
        m_prev = p;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s.bcd%0d", tag, i), {16'h0, bcd[i]}, {16'h0, to_bcd(m_val[i])});
            check_val($sformatf("%s.dir%0d", tag, i), {31'h0, dir_o[i]}, {31'h0, m_dir[i]});
            check_val($sformatf("%s.err%0d", tag, i), {31'h0, err_o[i]}, {31'h0, m_err[i]});
            check_val($sformatf("%s.steps%0d", tag, i), obs_steps[i], m_steps[i]);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move(input logic [1:0] p, input string tag);
        @(negedge clk);
        {qa, qb} = p;
        wait_neg(settle());
        model_move(p, 1'b0);
        check_all(tag);
    endtask

    task automatic move_up(input string tag);
        move(seq[(pos_of(m_prev) + 1) % 4], tag);
    endtask

    task automatic move_dn(input string tag);
        move(seq[(pos_of(m_prev) + 3) % 4], tag);
    endtask

    // Pair held one tick short of acceptance, then back to the stable pair
    task automatic glitch(input logic [1:0] p);
        @(negedge clk);
        {qa, qb} = p;
        wait_neg(se_cont ? FLT - 1 : 6);
        {qa, qb} = m_prev;
        wait_neg(settle());
        check_all("glitch");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_val[i] = init_val[i];
            m_err[i] = 1'b0;
        end
        wait_neg(2);
        check_all("clear");
    endtask

    task automatic do_reset(input logic [1:0] p);
        @(negedge clk);
        {qa, qb} = p;
        rst_n = 1'b0;
        wait_neg(3);
        for (int i = 0; i < 2; i++) begin
            m_val[i] = init_val[i];
            m_dir[i] = 1'b1;
            m_err[i] = 1'b0;
        end
        m_prev = 2'b00;
        check_all("in_reset");
        rst_n = 1'b1;
        wait_neg(settle());
        model_move(p, 1'b0);
        check_all("post_reset");
    endtask

    // Edge-to-step latency with continuous ticks: 2 + FLT + 2 clocks
    task automatic move_lat(input logic [1:0] p);
        @(negedge clk);
        {qa, qb} = p;
        wait_neg(7);
        check_val("lat_early", {31'h0, step_o[0]}, 32'h0);
        @(negedge clk);
        check_val("lat_step", {31'h0, step_o[0]}, 32'h1);
        wait_neg(4);
        model_move(p, 1'b0);
        check_all("lat");
    endtask

    // Clear raised exactly in the cycle the step would land
    task automatic move_clear(input logic [1:0] p);
        @(negedge clk);
        {qa, qb} = p;
        wait_neg(7);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clr_step_pulse", {31'h0, step_o[0]}, 32'h0);
        wait_neg(4);
        model_move(p, 1'b1);
        check_all("clr_step");
    endtask

    initial begin
        int r;
        int p;

        se_cont = 1'b1;
        do_reset(2'b00);

        // Full up cycle, ticks every third clock
        se_cont = 1'b0;
        move(2'b01, "up1");
        move(2'b11, "up2");
        move(2'b10, "up3");
        move(2'b00, "up4");
        check_val("up_cycle_x4", {16'h0, bcd[0]}, 32'h0004);
        check_val("up_cycle_x1", {16'h0, bcd[1]}, 32'h1235);
        do_clear();

        // Single down step from zero wraps to 9999
        move(2'b10, "dn_wrap");
        check_val("dn_wrap_bcd", {16'h0, bcd[0]}, 32'h9999);
        do_clear();
        move(2'b00, "back_up");

        // Walk up to 0099, then across the hundreds boundary and back
        se_cont = 1'b1;
        do_clear();
        for (int i = 0; i < 99; i++) move_up("preload");
        check_val("preload_bcd", {16'h0, bcd[0]}, 32'h0099);
        move_up("carry");
        check_val("carry_bcd", {16'h0, bcd[0]}, 32'h0100);
        move_dn("borrow");
        check_val("borrow_bcd", {16'h0, bcd[0]}, 32'h0099);

        // Short pulses on A are rejected in both tick modes
        glitch({~m_prev[1], m_prev[0]});
        se_cont = 1'b0;
        glitch({~m_prev[1], m_prev[0]});
        se_cont = 1'b1;

        // Both bits change together
        move(m_prev ^ 2'b11, "illegal");
        check_val("illegal_err", {31'h0, err_o[0]}, 32'h1);
        do_clear();

        // Two full up cycles in x1 mode count twice
        p = m_steps[1];
        for (int i = 0; i < 8; i++) move_up("x1_cycle");
        check_val("x1_two_steps", obs_steps[1] - p, 32'd2);

        move_lat(seq[(pos_of(m_prev) + 1) % 4]);
        move_clear(seq[(pos_of(m_prev) + 1) % 4]);

        // Encoder resting at 11 when reset releases
        do_reset(2'b11);
        check_val("reset_11_err", {31'h0, err_o[0]}, 32'h1);

        for (int it = 0; it < 80; it++) begin
            se_cont = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            p = pos_of(m_prev);
            if (r < 6) begin
                move(seq[(p + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4], "rnd_move");
            end else if (r == 6) begin
                move(seq[$urandom_range(0, 3)], "rnd_any");
            end else if (r < 9) begin
                glitch(seq[(p + 1 + $urandom_range(0, 2)) % 4]);
            end else begin
                do_clear();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
